// File: rtl/cpu_pkg.sv
// Shared definitions for the front end: widths, reset PC, opcodes, fetch FSM states.
package cpu_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Major opcodes, shared with the immediate extender and decoder
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_S      = 7'b0100011;
  localparam logic [6:0] OPC_B      = 7'b1100011;
  localparam logic [6:0] OPC_U_LUI  = 7'b0110111;
  localparam logic [6:0] OPC_U_AUI  = 7'b0010111;
  localparam logic [6:0] OPC_J      = 7'b1101111;

  // Fetch FSM: FETCH issues a request, WAIT holds until the single response returns
  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_WAIT  = 1'b1
  } fetch_state_t;

  // A redirect target is misaligned when either low address bit is set
  function automatic logic is_misaligned(input logic [1:0] lo_bits);
    return |lo_bits;
  endfunction

endpackage

// File: rtl/inst_fetch_buf.sv
// One-entry output register holding a fetched instruction and its PC.
// Priority: flush beats load beats drain. A load while the entry is
// draining simply replaces it, so a response never overwrites unread data.
module fetch_buf #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic            i_flush,
  input  logic            i_drain,
  input  logic [XLEN-1:0] i_inst,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_pc
);

  logic            r_valid;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_pc;

  // Valid flag: flush clears, load sets, drain clears
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  // Payload only changes on a load, so it is stable while stalled
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_inst <= '0;
      r_pc   <= '0;
    end else if (i_load && !i_flush) begin
      r_inst <= i_inst;
      r_pc   <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_inst  = r_inst;
  assign o_pc    = r_pc;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, keeps one memory request in flight and
// hands each instruction to decode through a one-entry buffer.
// Handshake: out_inst/out_pc transfer on a cycle where out_valid and
// out_ready are both high; while out_valid=1 and out_ready=0 the payload
// is held unchanged. A redirect flushes the buffer and voids any transfer
// in that same cycle.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC_DEFAULT,
  parameter int          XLEN     = cpu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            misalign_err,
  output logic            dbg_state
);

  localparam logic [XLEN-1:0] PC_STEP      = XLEN'(4);
  localparam logic [XLEN-1:0] PC_ALIGN_MSK = ~(XLEN'(3));
  localparam logic [XLEN-1:0] RESET_PC_AL  = XLEN'(RESET_PC) & PC_ALIGN_MSK;

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;
  logic            r_kill;
  logic            r_misalign;

  logic            w_buf_valid;
  logic            w_req;
  logic            w_load;
  logic            w_drain;
  logic [XLEN-1:0] w_redir_pc;

  // Issue only when the buffer is empty or being drained this cycle
  assign w_req      = (r_state == ST_FETCH) && (!w_buf_valid || out_ready);
  assign w_redir_pc = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_load     = (r_state == ST_WAIT) && imem_rvalid && !r_kill && !redirect_valid;
  assign w_drain    = w_buf_valid && out_ready;

  // Fetch FSM with PC, kill and misalign tracking; redirect has top priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_FETCH;
      r_pc       <= RESET_PC_AL;
      r_req_pc   <= '0;
      r_kill     <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= redirect_valid && is_misaligned(redirect_pc[1:0]);
      case (r_state)
        ST_FETCH: begin
          if (w_req && imem_gnt) begin
            // The old-PC request is already accepted; mark it wrong-path on redirect
            r_req_pc <= r_pc;
            r_pc     <= redirect_valid ? w_redir_pc : (r_pc + PC_STEP);
            r_kill   <= redirect_valid;
            r_state  <= ST_WAIT;
          end else if (redirect_valid) begin
            r_pc <= w_redir_pc;
          end
        end
        ST_WAIT: begin
          if (redirect_valid) begin
            r_pc <= w_redir_pc;
          end
          if (imem_rvalid) begin
            r_kill  <= 1'b0;
            r_state <= ST_FETCH;
          end else if (redirect_valid) begin
            r_kill <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

  fetch_buf #(
    .XLEN (XLEN)
  ) u_buf (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_load  (w_load),
    .i_flush (redirect_valid),
    .i_drain (w_drain),
    .i_inst  (imem_rdata),
    .i_pc    (r_req_pc),
    .o_valid (w_buf_valid),
    .o_inst  (out_inst),
    .o_pc    (out_pc)
  );

  assign imem_req     = w_req;
  assign imem_addr    = r_pc;
  assign out_valid    = w_buf_valid;
  assign misalign_err = r_misalign;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a small instruction-memory responder.
// Memory word at address A is 32'hA000_0000 | A.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        misalign_err;
  logic        dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  // Memory timing knobs: cycles of req before gnt, extra response cycles
  int gnt_delay = 0;
  int rsp_extra = 0;
  int gnt_cnt;
  int rsp_cnt;
  logic        pend;
  logic [31:0] pend_data;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0), .XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .misalign_err   (misalign_err),
    .dbg_state      (dbg_state)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  assign imem_gnt = imem_req && (gnt_cnt >= gnt_delay);

  // Memory responder, reset by the same rst as the fetch stage
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt     <= 0;
      rsp_cnt     <= 0;
      pend        <= 1'b0;
      pend_data   <= 32'h0;
      imem_rvalid <= 1'b0;
      imem_rdata  <= 32'h0;
    end else begin
      imem_rvalid <= 1'b0;
      gnt_cnt     <= (imem_req && !imem_gnt) ? gnt_cnt + 1 : 0;
      if (pend) begin
        if (rsp_cnt == 0) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= pend_data;
          pend        <= 1'b0;
        end else begin
          rsp_cnt <= rsp_cnt - 1;
        end
      end
      if (imem_req && imem_gnt) begin
        if (rsp_extra == 0) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= mem_word(imem_addr);
        end else begin
          pend      <= 1'b1;
          pend_data <= mem_word(imem_addr);
          rsp_cnt   <= rsp_extra - 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int gd, input int rx);
    gnt_delay      = gd;
    rsp_extra      = rx;
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    rst            = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
    ok = out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 00000000", imem_addr); end
    n_cmp++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got %0b exp 0", misalign_err); end
    n_cmp++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL reset_state got %0b exp 0", dbg_state); end
    n_cmp++; if (out_pc !== 32'h0 || out_inst !== 32'h0) begin n_fail++; $display("FAIL reset_payload got %h/%h exp 0/0", out_pc, out_inst); end
  endtask

  task automatic test_basic();
    do_reset(0, 0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL basic_req0 got %0b/%h exp 1/00000000", imem_req, imem_addr); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || imem_req !== 1'b0 || dbg_state !== 1'b1) begin n_fail++; $display("FAIL basic_wait got v%0b r%0b s%0b exp v0 r0 s1", out_valid, imem_req, dbg_state); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'(k * 4) || out_inst !== mem_word(32'(k * 4))) begin n_fail++; $display("FAIL basic_out%0d got v%0b %h/%h exp v1 %h/%h", k, out_valid, out_pc, out_inst, 32'(k * 4), mem_word(32'(k * 4))); end
      n_cmp++; if (imem_addr !== 32'(k * 4 + 4)) begin n_fail++; $display("FAIL basic_addr%0d got %h exp %h", k, imem_addr, 32'(k * 4 + 4)); end
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_gap%0d got %0b exp 0", k, out_valid); end
    end
  endtask

  task automatic test_stall();
    do_reset(0, 0);
    out_ready = 1'b0;
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'hA000_0000) begin n_fail++; $display("FAIL stall_hold%0d got v%0b %h/%h exp v1 00000000/a0000000", k, out_valid, out_pc, out_inst); end
      n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req%0d got %0b exp 0", k, imem_req); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL stall_resume got %0b/%h exp 1/00000004", imem_req, imem_addr); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || dbg_state !== 1'b1) begin n_fail++; $display("FAIL stall_drain got v%0b s%0b exp v0 s1", out_valid, dbg_state); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h4) begin n_fail++; $display("FAIL stall_next got v%0b %h exp v1 00000004", out_valid, out_pc); end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    do_reset(0, 1);
    for (int k = 0; k < 7; k++) tick();
    n_cmp++; if (dbg_state !== 1'b1 || imem_rvalid !== 1'b0 || imem_addr !== 32'hC) begin n_fail++; $display("FAIL rdw_pre got s%0b rv%0b %h exp s1 rv0 0000000c", dbg_state, imem_rvalid, imem_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || dbg_state !== 1'b1 || imem_rvalid !== 1'b1) begin n_fail++; $display("FAIL rdw_kill got v%0b s%0b rv%0b exp v0 s1 rv1", out_valid, dbg_state, imem_rvalid); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || dbg_state !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL rdw_drop got v%0b s%0b r%0b %h exp v0 s0 r1 00000100", out_valid, dbg_state, imem_req, imem_addr); end
    wait_valid(10, ok);
    n_cmp++; if (!ok || out_pc !== 32'h100 || out_inst !== 32'hA000_0100) begin n_fail++; $display("FAIL rdw_first got ok%0b %h/%h exp ok1 00000100/a0000100", ok, out_pc, out_inst); end
  endtask

  task automatic test_redirect_rvalid();
    do_reset(0, 0);
    tick();
    n_cmp++; if (imem_rvalid !== 1'b1 || dbg_state !== 1'b1) begin n_fail++; $display("FAIL rdr_pre got rv%0b s%0b exp rv1 s1", imem_rvalid, dbg_state); end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || dbg_state !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL rdr_drop got v%0b s%0b r%0b %h exp v0 s0 r1 00000200", out_valid, dbg_state, imem_req, imem_addr); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rdr_gap got %0b exp 0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_inst !== 32'hA000_0200) begin n_fail++; $display("FAIL rdr_first got v%0b %h/%h exp v1 00000200/a0000200", out_valid, out_pc, out_inst); end
  endtask

  task automatic test_misalign();
    bit ok;
    do_reset(0, 0);
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (misalign_err !== 1'b1 || dbg_state !== 1'b1 || imem_addr !== 32'h100 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mis_pulse got m%0b s%0b %h v%0b exp m1 s1 00000100 v0", misalign_err, dbg_state, imem_addr, out_valid); end
    tick();
    n_cmp++; if (misalign_err !== 1'b0 || out_valid !== 1'b0 || dbg_state !== 1'b0 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL mis_after got m%0b v%0b s%0b %h exp m0 v0 s0 00000100", misalign_err, out_valid, dbg_state, imem_addr); end
    wait_valid(10, ok);
    n_cmp++; if (!ok || out_pc !== 32'h100 || out_inst !== 32'hA000_0100) begin n_fail++; $display("FAIL mis_first got ok%0b %h/%h exp ok1 00000100/a0000100", ok, out_pc, out_inst); end
  endtask

  task automatic test_flush_vs_ready();
    bit ok;
    do_reset(0, 0);
    out_ready = 1'b0;
    tick(); tick();
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || dbg_state !== 1'b1 || imem_addr !== 32'h300 || misalign_err !== 1'b0) begin n_fail++; $display("FAIL fvr_flush got v%0b s%0b %h m%0b exp v0 s1 00000300 m0", out_valid, dbg_state, imem_addr, misalign_err); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || dbg_state !== 1'b0 || imem_addr !== 32'h300) begin n_fail++; $display("FAIL fvr_drop got v%0b s%0b %h exp v0 s0 00000300", out_valid, dbg_state, imem_addr); end
    wait_valid(10, ok);
    n_cmp++; if (!ok || out_pc !== 32'h300 || out_inst !== 32'hA000_0300) begin n_fail++; $display("FAIL fvr_first got ok%0b %h/%h exp ok1 00000300/a0000300", ok, out_pc, out_inst); end
  endtask

  task automatic test_redirect_fetch();
    bit ok;
    do_reset(3, 0);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (dbg_state !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL rdf_addr got s%0b r%0b %h exp s0 r1 00000040", dbg_state, imem_req, imem_addr); end
    wait_valid(20, ok);
    n_cmp++; if (!ok || out_pc !== 32'h40 || out_inst !== 32'hA000_0040) begin n_fail++; $display("FAIL rdf_first got ok%0b %h/%h exp ok1 00000040/a0000040", ok, out_pc, out_inst); end
  endtask

  task automatic test_gnt_delay();
    do_reset(3, 0);
    for (int k = 0; k < 5; k++) tick();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_fail++; $display("FAIL gd_first got v%0b %h exp v1 00000000", out_valid, out_pc); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (imem_req !== 1'b1 || imem_gnt !== 1'b0 || imem_addr !== 32'h4 || dbg_state !== 1'b0) begin n_fail++; $display("FAIL gd_hold%0d got r%0b g%0b %h s%0b exp r1 g0 00000004 s0", k, imem_req, imem_gnt, imem_addr, dbg_state); end
      tick();
    end
    n_cmp++; if (imem_gnt !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL gd_gnt got g%0b %h exp g1 00000004", imem_gnt, imem_addr); end
    tick();
    n_cmp++; if (imem_addr !== 32'h8 || dbg_state !== 1'b1) begin n_fail++; $display("FAIL gd_adv got %h s%0b exp 00000008 s1", imem_addr, dbg_state); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_inst !== 32'hA000_0004) begin n_fail++; $display("FAIL gd_out got v%0b %h/%h exp v1 00000004/a0000004", out_valid, out_pc, out_inst); end
  endtask

  task automatic test_async_reset();
    do_reset(0, 2);
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (dbg_state !== 1'b0 || out_valid !== 1'b0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL ar_wait got s%0b v%0b %h exp s0 v0 00000000", dbg_state, out_valid, imem_addr); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL ar_first got r%0b %h exp r1 00000000", imem_req, imem_addr); end
    rsp_extra = 0; out_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_loaded got %0b exp 1", out_valid); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_inst !== 32'h0) begin n_fail++; $display("FAIL ar_drop got v%0b %h exp v0 00000000", out_valid, out_inst); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_misalign();
    test_flush_vs_ready();
    test_redirect_fetch();
    test_gnt_delay();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
